// File: rtl/demux_stream_router_if.sv
// Stream bundle for the 1-to-4 router: one valid/ready input stream and
// four registered valid/ready output channels, packed side by side.
interface demux_stream_router_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;

    // Producer of in_* and consumer of out_*.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // The router itself.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_stream_router.sv
// Sequential 1-to-4 stream distributor: each accepted word lands in a
// one-entry register of the channel picked by in_sel or a round-robin pointer.
module demux_stream_router #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    demux_stream_router_if.slave    bus,
    input  logic                    rr_mode,
    input  logic                    flush,
    output logic                    sel_s1,
    output logic                    sel_s0,
    output logic [CNT_W-1:0]        acc_cnt
);

    logic [1:0]       rr_ptr;
    logic [1:0]       dest;
    logic [3:0]       full;
    logic [WIDTH-1:0] data_q [4];
    logic             accept;

    // in_sel is only looked at in explicit mode, so an X on it cannot leak
    // into routing while round-robin is active.
    assign dest   = rr_mode ? rr_ptr : bus.in_sel;
    assign sel_s1 = dest[1];
    assign sel_s0 = dest[0];

    // A full channel may still accept when its consumer drains it this cycle,
    // which is what gives one word per cycle per channel.
    assign bus.in_ready = ~flush & (~full[dest] | bus.out_ready[dest]);
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid = full;

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < 4; k++) begin
            bus.out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    // Occupancy flags: reload wins over drain, flush wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else if (flush) begin
            full <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && dest == 2'(k)) begin
                    full[k] <= 1'b1;
                end else if (full[k] && bus.out_ready[k]) begin
                    full[k] <= 1'b0;
                end
            end
        end
    end

    // NOTE: the data registers are reset too, because out_data must read zero
    // while rst_n is low; without that requirement they could go unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else if (accept) begin
            data_q[dest] <= bus.in_data;
        end
    end

    // The pointer moves only on a round-robin accept, never on mode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 2'd0;
        end else if (accept && rr_mode) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (accept && acc_cnt != {CNT_W{1'b1}}) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
Sequential 1-to-4 stream distributor. It accepts WIDTH-bit words on a single valid/ready input and routes each word to one of four registered output channels, each with its own valid/ready handshake. The destination is either an explicit 2-bit select or an internal round-robin pointer. It sits in front of, and replaces ad-hoc use of, the combinational 1:4 demux: it produces registered, back-pressured channel outputs plus the current select bits for debug.

Parameters:
WIDTH, 8, data word width in bits
CNT_W, 8, width of the accepted-word counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  input word
in_sel  input  2  explicit destination channel (used when rr_mode=0)
in_valid  input  1  input word valid
in_ready  output  1  router can accept the word this cycle
rr_mode  input  1  1 = round-robin destination, 0 = in_sel destination
flush  input  1  synchronous clear of all channel registers
out_data  output  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
out_valid  output  4  per-channel data valid
out_ready  input  4  per-channel consumer ready
sel_s1  output  1  bit 1 of the current destination (dest[1])
sel_s0  output  1  bit 0 of the current destination (dest[0])
acc_cnt  output  CNT_W  total words accepted, saturating

Behaviour:
- Reset is asynchronous and active-low (rst_n). While rst_n=0: full[3:0]=0, out_valid=0, out_data=0, rr_ptr=0, acc_cnt=0.
- dest = rr_mode ? rr_ptr : in_sel. Combinational; also drives sel_s1/sel_s0.
- Per channel k: a one-entry register data_k plus a full_k flag; out_valid[k] = full_k.
- in_ready = ~flush & (~full[dest] | out_ready[dest]). Combinational on dest, full and out_ready.
- Accept when in_valid & in_ready. On the next edge: data_dest <= in_data, full_dest <= 1. Latency is 1 cycle from accept to out_valid.
- Drain: when out_valid[k] & out_ready[k], full_k clears on the next edge, unless channel k is reloaded in the same cycle. Simultaneous drain and reload keeps full_k=1 with the new data, giving full throughput of 1 word/cycle per channel.
- out_data of channel k holds its last value after a drain. It changes only on load or reset.
- Round-robin pointer: rr_ptr advances 0→1→2→3→0 only on an accept while rr_mode=1. Cycles with no accept leave it unchanged.
- rr_mode toggling never resets rr_ptr. Accepts in explicit mode do not move rr_ptr.
- Round-robin blocks on a full channel; it does not skip to the next free channel. in_ready=0 until channel rr_ptr drains.
- flush=1: on the next edge all full_k <= 0. in_ready=0 during the flush cycle, so no accept occurs. rr_ptr and acc_cnt are unchanged. Data registers are unchanged.
- acc_cnt increments by 1 per accept and saturates at 2^CNT_W-1 (no wrap).
- in_valid=1 with in_ready=0: the word is not consumed. The source holds it, and the router places no constraint on data stability.
- Reset asserted mid-transfer discards all held words immediately (asynchronous). The first accept after release goes to channel 0 in rr_mode.
- No X propagation: in_sel is sampled only when rr_mode=0.

Test Plan:
- Reset then explicit mode, out_ready=4'b1111: send 0xA0..0xA3 with in_sel=0,1,2,3 on consecutive cycles → out_valid[k] pulses one cycle after each accept, out_data[k]=0xA0+k, acc_cnt=4, in_ready stays 1.
- rr_mode=1, out_ready=4'b1111: send 6 words 0x10..0x15 back-to-back → land on channels 0,1,2,3,0,1; rr_ptr ends at 2; sel_s1/sel_s0 track dest each cycle.
- Backpressure: out_ready[2]=0, in_sel=2, send 0x55 then 0x66 → 0x55 held on ch2, in_ready=0 for 0x66. Raise out_ready[2] → the same cycle accepts 0x66 while 0x55 drains, and out_valid[2] stays 1 with data 0x66.
- Round-robin blocking: fill ch1 with out_ready[1]=0, rr_ptr=1 → in_ready=0 and rr_ptr stays 1 despite in_valid=1 for 5 cycles. Release out_ready[1] → the word goes to ch1 and rr_ptr becomes 2.
- flush with all four channels full → in_ready=0 that cycle, out_valid=4'b0000 next cycle, acc_cnt and rr_ptr unchanged.
- CNT_W=4: accept 20 words → acc_cnt saturates at 15. Assert rst_n=0 mid-stream → outputs are 0 immediately without waiting for clk.
